// File: rtl/highlight_frame_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : highlight_pkg
// Brief    : Shared types, widths and helpers for the pedestrian-highlight
//            stage (frame controller and pixel selector).
// Revision : 1.0 - initial release
// ============================================================================
package highlight_pkg;

   localparam int PIXEL_W = 24;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } hl_state_t;

   // A pixel is highlighted when its mask byte reaches the threshold.
   function automatic logic is_highlight(input logic [7:0] mask,
                                         input logic [7:0] thresh);
      return (mask >= thresh);
   endfunction

endpackage
`default_nettype wire

// File: rtl/highlight_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : highlight_frame_ctrl_if
// Brief    : Control, FIFO-read and FIFO-write signals of the highlight frame
//            controller. The slave modport is the controller itself; the
//            master modport is the surrounding frame top plus FIFOs.
// Revision : 1.0 - initial release
// ============================================================================
interface highlight_frame_ctrl_if #(
   parameter int CW = 19
) ();

   logic                                start;
   logic                                busy;
   logic                                done;
   logic [CW-1:0]                       hl_count;
   logic                                in_rd_en_ped;
   logic                                in_rd_en_mask;
   logic                                in_empty_ped;
   logic                                in_empty_mask;
   logic [highlight_pkg::PIXEL_W-1:0]   in_dout_ped;
   logic [highlight_pkg::PIXEL_W-1:0]   in_dout_mask;
   logic                                out_wr_en;
   logic                                out_full;
   logic [highlight_pkg::PIXEL_W-1:0]   out_din;

   modport master (
      output start,
      input  busy,
      input  done,
      input  hl_count,
      input  in_rd_en_ped,
      input  in_rd_en_mask,
      output in_empty_ped,
      output in_empty_mask,
      output in_dout_ped,
      output in_dout_mask,
      input  out_wr_en,
      output out_full,
      input  out_din
   );

   modport slave (
      input  start,
      output busy,
      output done,
      output hl_count,
      output in_rd_en_ped,
      output in_rd_en_mask,
      input  in_empty_ped,
      input  in_empty_mask,
      input  in_dout_ped,
      input  in_dout_mask,
      output out_wr_en,
      input  out_full,
      output out_din
   );

endinterface
`default_nettype wire

// File: rtl/highlight_frame_ctrl_pixel_sel.sv
`default_nettype none
// ============================================================================
// Module   : highlight_pixel_sel
// Brief    : Combinational pixel selector: replaces the ped pixel with the
//            highlight colour when the mask byte reaches the threshold.
// Revision : 1.0 - initial release
// ============================================================================
module highlight_pixel_sel
   import highlight_pkg::*;
#(
   parameter logic [7:0]         MASK_THRESH = 8'hff,
   parameter logic [PIXEL_W-1:0] HL_COLOR    = 24'h0000ff
) (
   input  wire logic [PIXEL_W-1:0] i_ped,
   input  wire logic [PIXEL_W-1:0] i_mask,
   output logic      [PIXEL_W-1:0] o_pixel,
   output logic                    o_hit
);

   // Only the low mask byte carries information; the upper bits are ignored.
   logic w_unused_mask_hi;
   assign w_unused_mask_hi = ^i_mask[PIXEL_W-1:8];

   assign o_hit   = is_highlight(i_mask[7:0], MASK_THRESH);
   assign o_pixel = o_hit ? HL_COLOR : i_ped;

endmodule
`default_nettype wire

// File: rtl/highlight_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : highlight_frame_ctrl
// Brief    : Frame sequencer for the pedestrian-highlight stage. Pops
//            WIDTH*HEIGHT ped/mask pairs, substitutes highlighted pixels and
//            pushes results through a one-entry holding register.
// Revision : 1.0 - initial release
// ============================================================================
module highlight_frame_ctrl
   import highlight_pkg::*;
#(
   parameter int                 WIDTH       = 720,
   parameter int                 HEIGHT      = 540,
   parameter logic [7:0]         MASK_THRESH = 8'hff,
   parameter logic [PIXEL_W-1:0] HL_COLOR    = 24'h0000ff
) (
   input wire logic              clock,
   input wire logic              reset,
   highlight_frame_ctrl_if.slave bus
);

   localparam int c_CW    = $clog2(WIDTH * HEIGHT + 1);
   localparam int c_COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int c_ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(WIDTH - 1);
   localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(HEIGHT - 1);

   hl_state_t          r_state;
   hl_state_t          w_state_nxt;
   logic [PIXEL_W-1:0] r_hold;
   logic               r_hold_v;
   logic [c_COL_W-1:0] r_col;
   logic [c_ROW_W-1:0] r_row;
   logic [c_CW-1:0]    r_hl_count;

   logic               w_pop;
   logic               w_wr;
   logic               w_last;
   logic               w_start_ok;
   logic               w_busy;
   logic               w_done;
   logic               w_hit;
   logic [PIXEL_W-1:0] w_sel_pixel;

   highlight_pixel_sel #(
      .MASK_THRESH (MASK_THRESH),
      .HL_COLOR    (HL_COLOR)
   ) u_pixel_sel (
      .i_ped   (bus.in_dout_ped),
      .i_mask  (bus.in_dout_mask),
      .o_pixel (w_sel_pixel),
      .o_hit   (w_hit)
   );

   // Both FIFOs are popped together, only when both hold data and the
   // holding register can accept (empty, or draining this cycle). Reset
   // blocks pops/pushes so a discarded frame does not consume FIFO data.
   assign w_wr       = r_hold_v & ~bus.out_full & ~reset;
   assign w_pop      = (r_state == RUN) & ~bus.in_empty_ped & ~bus.in_empty_mask
                     & (~r_hold_v | ~bus.out_full) & ~reset;
   assign w_last     = (r_col == c_COL_LAST) & (r_row == c_ROW_LAST);
   assign w_start_ok = (r_state == IDLE) & bus.start;

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and status decode.
   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) w_state_nxt = RUN;
         end
         RUN: begin
            w_busy = 1'b1;
            if (w_pop && w_last) w_state_nxt = FLUSH;
         end
         FLUSH: begin
            w_busy = 1'b1;
            if (w_wr || !r_hold_v) w_state_nxt = DONE;
         end
         DONE: begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Holding register, raster counters and highlight counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_hold     <= '0;
         r_hold_v   <= 1'b0;
         r_col      <= '0;
         r_row      <= '0;
         r_hl_count <= '0;
      end else begin
         if (w_start_ok) begin
            r_col      <= '0;
            r_row      <= '0;
            r_hl_count <= '0;
         end
         if (w_pop) begin
            r_hold     <= w_sel_pixel;
            r_hold_v   <= 1'b1;
            r_hl_count <= r_hl_count + c_CW'(w_hit);
            if (r_col == c_COL_LAST) begin
               r_col <= '0;
               r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end else if (w_wr) begin
            r_hold_v <= 1'b0;
         end
      end
   end

   assign bus.in_rd_en_ped  = w_pop;
   assign bus.in_rd_en_mask = w_pop;
   assign bus.out_wr_en     = w_wr;
   assign bus.out_din       = w_wr ? r_hold : '0;
   assign bus.busy          = w_busy;
   assign bus.done          = w_done;
   assign bus.hl_count      = r_hl_count;

endmodule
`default_nettype wire

// File: tb/tb_highlight_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_highlight_frame_ctrl
// Brief    : Self-checking bench for highlight_frame_ctrl (4x2 frame) with
//            FIFO models and an expected-pixel scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_highlight_frame_ctrl;

   localparam int          WIDTH       = 4;
   localparam int          HEIGHT      = 2;
   localparam int          NPIX        = WIDTH * HEIGHT;
   localparam int          CW          = $clog2(WIDTH * HEIGHT + 1);
   localparam logic [7:0]  MASK_THRESH = 8'hff;
   localparam logic [23:0] HL_COLOR    = 24'h0000ff;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   highlight_frame_ctrl_if #(.CW(CW)) bus ();

   highlight_frame_ctrl #(
      .WIDTH       (WIDTH),
      .HEIGHT      (HEIGHT),
      .MASK_THRESH (MASK_THRESH),
      .HL_COLOR    (HL_COLOR)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   logic [23:0] ped_q[$];
   logic [23:0] mask_q[$];
   logic [24:0] exp_q[$];

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   logic start_ctl, reset_ctl, full_ctl, force_mask_empty;

   int   f_pops, f_wr, f_done, first_pop, last_pop, first_wr, last_wr, done_cyc;
   int   stall_pops, mempty_pops;
   logic busy_at_done, busy_seen;
   int   hits;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic clear_stats();
      f_pops = 0; f_wr = 0; f_done = 0;
      first_pop = 0; last_pop = 0; first_wr = 0; last_wr = 0; done_cyc = 0;
      stall_pops = 0; mempty_pops = 0;
      busy_at_done = 1'b1; busy_seen = 1'b0;
   endtask

   // Sample the settled outputs that the DUT will act on at the next edge.
   task automatic observe();
      logic [24:0] exp_v;
      cyc++;
      check("rd_en_pair", 32'(bus.in_rd_en_mask), 32'(bus.in_rd_en_ped));
      if (!bus.out_wr_en) check("din_idle", 32'(bus.out_din), 32'h0);
      if (bus.out_full)   check("wr_while_full", 32'(bus.out_wr_en), 32'h0);
      if (bus.in_rd_en_ped) begin
         check("rd_gate", 32'({bus.in_empty_ped, bus.in_empty_mask}), 32'h0);
         if (full_ctl) stall_pops++;
         if (force_mask_empty) mempty_pops++;
         if (ped_q.size() != 0)  void'(ped_q.pop_front());
         if (mask_q.size() != 0) void'(mask_q.pop_front());
         if (f_pops == 0) first_pop = cyc;
         last_pop = cyc;
         f_pops++;
      end
      if (bus.out_wr_en) begin
         if (exp_q.size() != 0) exp_v = exp_q.pop_front();
         else                   exp_v = 25'h1000000;
         check("out_din", 32'({1'b0, bus.out_din}), 32'(exp_v));
         if (f_wr == 0) first_wr = cyc;
         last_wr = cyc;
         f_wr++;
      end
      if (bus.done) begin
         f_done++;
         done_cyc     = cyc;
         busy_at_done = bus.busy;
      end
      if (bus.busy) busy_seen = 1'b1;
   endtask

   // Drive all inputs at the falling edge, then observe.
   task automatic tick();
      @(negedge clock);
      reset             = reset_ctl;
      bus.start         = start_ctl;
      bus.out_full      = full_ctl;
      bus.in_empty_ped  = (ped_q.size() == 0);
      bus.in_empty_mask = (mask_q.size() == 0) || force_mask_empty;
      bus.in_dout_ped   = (ped_q.size()  != 0) ? ped_q[0]  : 24'h0;
      bus.in_dout_mask  = (mask_q.size() != 0) ? mask_q[0] : 24'h0;
      #1;
      observe();
   endtask

   // Queue a frame; masks[8*i +: 8] is the mask byte of pixel i.
   task automatic load_frame(input logic [63:0] masks, input bit rnd, output int n_hits);
      logic [23:0] p;
      logic [23:0] m;
      n_hits = 0;
      for (int i = 0; i < NPIX; i++) begin
         p = rnd ? 24'($urandom) : (24'h111100 | 24'(i));
         m = {16'($urandom), masks[8*i +: 8]};
         ped_q.push_back(p);
         mask_q.push_back(m);
         if (m[7:0] >= MASK_THRESH) begin
            exp_q.push_back({1'b0, HL_COLOR});
            n_hits++;
         end else begin
            exp_q.push_back({1'b0, p});
         end
      end
   endtask

   task automatic start_frame();
      clear_stats();
      start_ctl = 1'b1;
      tick();
      start_ctl = 1'b0;
      tick();
      check("busy_after_start", 32'(bus.busy), 32'h1);
   endtask

   task automatic run_to_done(input int full_at, input int full_len,
                              input int me_at, input int me_len,
                              input bit pulse_run, input bit pulse_done);
      int full_left = 0;
      int me_left   = 0;
      bit full_used = 1'b0;
      bit me_used   = 1'b0;
      int t0        = cyc;
      while (f_done == 0 && (cyc - t0) < 200) begin
         if (!full_used && full_at >= 0 && f_wr == full_at) begin
            full_left = full_len; full_used = 1'b1;
         end
         if (!me_used && me_at >= 0 && f_pops == me_at) begin
            me_left = me_len; me_used = 1'b1;
         end
         full_ctl         = (full_left > 0);
         force_mask_empty = (me_left > 0);
         start_ctl        = pulse_run && (f_pops == 4);
         tick();
         if (full_left > 0) full_left--;
         if (me_left > 0)   me_left--;
         if (pulse_done && bus.done) begin
            bus.start = 1'b1;
            #1;
         end
      end
      full_ctl = 1'b0; force_mask_empty = 1'b0; start_ctl = 1'b0;
      check("done_seen", 32'(f_done), 32'h1);
   endtask

   task automatic post_checks(input int exp_hl);
      busy_seen = 1'b0;
      repeat (3) tick();
      check("no_restart_busy", 32'(busy_seen), 32'h0);
      check("wr_count", 32'(f_wr), 32'(NPIX));
      check("pop_count", 32'(f_pops), 32'(NPIX));
      check("exp_left", 32'(exp_q.size()), 32'h0);
      check("hl_count", 32'(bus.hl_count), 32'(exp_hl));
      check("done_count", 32'(f_done), 32'h1);
      check("busy_at_done", 32'(busy_at_done), 32'h0);
   endtask

   initial begin
      reset = 1'b1; reset_ctl = 1'b1; start_ctl = 1'b0;
      full_ctl = 1'b0; force_mask_empty = 1'b0;
      bus.start = 1'b0; bus.out_full = 1'b0;
      bus.in_empty_ped = 1'b1; bus.in_empty_mask = 1'b1;
      bus.in_dout_ped = '0; bus.in_dout_mask = '0;
      clear_stats();

      // Reset state
      repeat (2) tick();
      check("rst_ctrl", 32'({bus.busy, bus.done, bus.in_rd_en_ped, bus.in_rd_en_mask, bus.out_wr_en}), 32'h0);
      check("rst_hl_count", 32'(bus.hl_count), 32'h0);
      check("rst_out_din", 32'(bus.out_din), 32'h0);
      reset_ctl = 1'b0;
      tick();

      // Test 1: basic frame
      load_frame(64'h000000ffff00ff00, 1'b0, hits);
      check("t1_model_hits", 32'(hits), 32'd3);
      start_frame();
      run_to_done(-1, 0, -1, 0, 1'b0, 1'b0);
      post_checks(3);

      // Test 2: throughput with a random pattern
      load_frame({8'hff, 8'h00, 8'hff, 8'hfe, 8'h80, 8'hff, 8'hff, 8'h01}, 1'b1, hits);
      start_frame();
      run_to_done(-1, 0, -1, 0, 1'b0, 1'b0);
      check("t2_pop_span", 32'(last_pop - first_pop), 32'(NPIX - 1));
      check("t2_wr_span", 32'(last_wr - first_wr), 32'(NPIX - 1));
      check("t2_latency", 32'(first_wr - first_pop), 32'd1);
      check("t2_done_lat", 32'(done_cyc - last_pop), 32'd2);
      post_checks(hits);

      // Test 3: output backpressure for 5 cycles at pixel 2
      load_frame(64'h000000ffff00ff00, 1'b0, hits);
      start_frame();
      run_to_done(2, 5, -1, 0, 1'b0, 1'b0);
      check("t3_stall_pops_le1", 32'(stall_pops <= 1), 32'h1);
      post_checks(3);

      // Test 4: mask FIFO empty for 4 cycles while ped has data
      load_frame(64'h01fffe00ff7ffffe, 1'b0, hits);
      check("t4_model_hits", 32'(hits), 32'd3);
      start_frame();
      run_to_done(-1, 0, 3, 4, 1'b0, 1'b0);
      check("t4_unbal_pops", 32'(mempty_pops), 32'h0);
      post_checks(3);

      // Test 5: reset after 3 pixels, then a fresh frame
      load_frame(64'h000000ffff00ff00, 1'b0, hits);
      start_frame();
      for (int i = 0; i < 50 && f_pops < 3; i++) tick();
      check("t5_pre_pops", 32'(f_pops), 32'd3);
      reset_ctl = 1'b1;
      tick();
      check("t5_rst_outs", 32'({bus.in_rd_en_ped, bus.in_rd_en_mask, bus.out_wr_en}), 32'h0);
      check("t5_rst_din", 32'(bus.out_din), 32'h0);
      reset_ctl = 1'b0;
      ped_q.delete(); mask_q.delete(); exp_q.delete();
      tick();
      check("t5_post_rst", 32'({bus.busy, bus.done, bus.out_wr_en, bus.in_rd_en_ped}), 32'h0);
      check("t5_hl_cleared", 32'(bus.hl_count), 32'h0);
      load_frame(64'hff00ff00ff00ff00, 1'b0, hits);
      start_frame();
      run_to_done(-1, 0, -1, 0, 1'b0, 1'b0);
      post_checks(4);

      // Test 6: start pulsed in RUN and in DONE is ignored
      load_frame(64'h00ff00ff00ff00ff, 1'b1, hits);
      start_frame();
      run_to_done(-1, 0, -1, 0, 1'b1, 1'b1);
      post_checks(4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
